// File: rtl/mem_msgs_pkg.sv
// Memory request/response message formats for 4-byte word accesses.
package mem_msgs;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;     // 0 encodes a full 4-byte access
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

// File: rtl/xcel_msgs_pkg.sv
// Processor <-> accelerator request/response message formats.
package xcel_msgs;

  localparam logic XCEL_TYPE_READ  = 1'b0;
  localparam logic XCEL_TYPE_WRITE = 1'b1;

  localparam logic [4:0] XR_GO   = 5'd0;
  localparam logic [4:0] XR_BASE = 5'd1;
  localparam logic [4:0] XR_SIZE = 5'd2;

  typedef struct packed {
    logic [7:0]  opaque;
    logic        type_;
    logic [4:0]  addr;
    logic [31:0] data;
  } xcel_req_t;

  typedef struct packed {
    logic [7:0]  opaque;
    logic        type_;
    logic [31:0] data;
  } xcel_resp_t;

endpackage

// File: rtl/xcel_sum_accel_pkg.sv
// Local types and helpers for the summing accelerator.
package xcel_sum_accel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Word address of element idx of the array starting at base.
  function automatic logic [31:0] elem_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/xcel_sum_accel_ctrl.sv
// Control for the summing accelerator: run state, issue/receive counters,
// in-flight credit check and all handshake valid/ready signals.
module xcel_sum_accel_ctrl
  import xcel_sum_accel_pkg::*;
#(
  parameter int unsigned P_MAX_INFLIGHT = 4
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        xcel_req_val_i,
  input  logic        go_i,            // accepted write to the go register
  input  logic        xcel_resp_rdy_i,
  input  logic        memreq_rdy_i,
  input  logic        memresp_val_i,
  input  logic [31:0] size_i,
  output logic        xcel_req_rdy_o,
  output logic        xcel_resp_val_o,
  output logic        memreq_val_o,
  output logic        memresp_rdy_o,
  output logic [31:0] issued_o
);

  state_e      state_q, state_d;
  logic [31:0] issued_q, issued_d;
  logic [31:0] received_q, received_d;
  logic        resp_val_q, resp_val_d;
  logic        memreq_fire, memresp_fire;

  // Next-state, counters and handshake outputs
  always_comb begin
    state_d        = state_q;
    memresp_rdy_o  = (state_q == CALC);
    memreq_val_o   = (state_q == CALC) && (issued_q < size_i) &&
                     ((issued_q - received_q) < 32'(P_MAX_INFLIGHT));
    xcel_req_rdy_o = (state_q == IDLE) && (!resp_val_q || xcel_resp_rdy_i);
    memreq_fire    = memreq_val_o && memreq_rdy_i;
    memresp_fire   = memresp_val_i && memresp_rdy_o;
    issued_d       = issued_q + 32'(memreq_fire);
    received_d     = received_q + 32'(memresp_fire);

    // one-entry response slot: refill on accept, drain on downstream ready
    resp_val_d = resp_val_q;
    if (xcel_req_val_i && xcel_req_rdy_o) resp_val_d = 1'b1;
    else if (xcel_resp_rdy_i)             resp_val_d = 1'b0;

    case (state_q)
      IDLE: if (go_i) begin
        state_d    = CALC;
        issued_d   = '0;
        received_d = '0;
      end
      CALC: if (received_d == size_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      received_q <= '0;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      resp_val_q <= resp_val_d;
    end
  end

  assign xcel_resp_val_o = resp_val_q;
  assign issued_o        = issued_q;

endmodule

// File: rtl/xcel_sum_accel.sv
// Summing accelerator: configure base/size through xcel registers, write xr0
// to stream-read size words from memory and accumulate; read xr0 for the sum.
module xcel_sum_accel
  import xcel_msgs::*;
  import mem_msgs::*;
  import xcel_sum_accel_pkg::*;
#(
  parameter int unsigned p_max_inflight = 4
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         xcel_reqstream_val,
  output logic         xcel_reqstream_rdy,
  input  xcel_req_t    xcel_reqstream_msg,
  output logic         xcel_respstream_val,
  input  logic         xcel_respstream_rdy,
  output xcel_resp_t   xcel_respstream_msg,
  output logic         memreq_val,
  input  logic         memreq_rdy,
  output mem_req_4B_t  memreq_msg,
  input  logic         memresp_val,
  output logic         memresp_rdy,
  input  mem_resp_4B_t memresp_msg
);

  logic [31:0] base_q, base_d;
  logic [31:0] size_q, size_d;
  logic [31:0] sum_q, sum_d;
  xcel_resp_t  resp_q, resp_d;
  logic [31:0] issued;
  logic        req_fire, go;

  assign req_fire = xcel_reqstream_val && xcel_reqstream_rdy;
  assign go       = req_fire && (xcel_reqstream_msg.type_ == XCEL_TYPE_WRITE) &&
                    (xcel_reqstream_msg.addr == XR_GO);

  xcel_sum_accel_ctrl #(.P_MAX_INFLIGHT(p_max_inflight)) u_ctrl (
    .clk             (clk),
    .reset           (reset),
    .xcel_req_val_i  (xcel_reqstream_val),
    .go_i            (go),
    .xcel_resp_rdy_i (xcel_respstream_rdy),
    .memreq_rdy_i    (memreq_rdy),
    .memresp_val_i   (memresp_val),
    .size_i          (size_q),
    .xcel_req_rdy_o  (xcel_reqstream_rdy),
    .xcel_resp_val_o (xcel_respstream_val),
    .memreq_val_o    (memreq_val),
    .memresp_rdy_o   (memresp_rdy),
    .issued_o        (issued)
  );

  // Register decode, response formation and accumulation
  always_comb begin
    base_d = base_q;
    size_d = size_q;
    sum_d  = sum_q;
    resp_d = resp_q;
    if (req_fire) begin
      resp_d.opaque = xcel_reqstream_msg.opaque;
      resp_d.type_  = xcel_reqstream_msg.type_;
      resp_d.data   = '0;
      if (xcel_reqstream_msg.type_ == XCEL_TYPE_WRITE) begin
        case (xcel_reqstream_msg.addr)
          XR_GO:   sum_d  = '0;
          XR_BASE: base_d = xcel_reqstream_msg.data;
          XR_SIZE: size_d = xcel_reqstream_msg.data;
          default: ;
        endcase
      end else begin
        case (xcel_reqstream_msg.addr)
          XR_GO:   resp_d.data = sum_q;
          XR_BASE: resp_d.data = base_q;
          XR_SIZE: resp_d.data = size_q;
          default: resp_d.data = '0;
        endcase
      end
    end
    // go is only accepted in IDLE and responses only in CALC, so no overlap
    if (memresp_val && memresp_rdy) sum_d = sum_q + memresp_msg.data;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      size_q <= '0;
      sum_q  <= '0;
      resp_q <= '0;
    end else begin
      base_q <= base_d;
      size_q <= size_d;
      sum_q  <= sum_d;
      resp_q <= resp_d;
    end
  end

  assign xcel_respstream_msg = resp_q;

  always_comb begin
    memreq_msg        = '0;
    memreq_msg.type_  = MEM_TYPE_READ;
    memreq_msg.opaque = issued[7:0];
    memreq_msg.addr   = elem_addr(base_q, issued);
  end

  // Responses arrive in order; only the data field carries information.
  logic unused_memresp;
  assign unused_memresp = ^{memresp_msg.type_, memresp_msg.opaque,
                            memresp_msg.test, memresp_msg.len};

endmodule

// File: tb/tb_xcel_sum_accel.sv
// Directed bench for xcel_sum_accel with a reference model of the register
// file, a latency-configurable memory, and a per-cycle monitor.
module tb_xcel_sum_accel;
  import xcel_msgs::*;
  import mem_msgs::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         xcel_reqstream_val = 1'b0;
  logic         xcel_reqstream_rdy;
  xcel_req_t    xcel_reqstream_msg = '0;
  logic         xcel_respstream_val;
  logic         xcel_respstream_rdy = 1'b1;
  xcel_resp_t   xcel_respstream_msg;
  logic         memreq_val;
  logic         memreq_rdy = 1'b1;
  mem_req_4B_t  memreq_msg;
  logic         memresp_val = 1'b0;
  logic         memresp_rdy;
  mem_resp_4B_t memresp_msg = '0;

  always #5 clk = ~clk;

  xcel_sum_accel #(.p_max_inflight(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .xcel_reqstream_val  (xcel_reqstream_val),
    .xcel_reqstream_rdy  (xcel_reqstream_rdy),
    .xcel_reqstream_msg  (xcel_reqstream_msg),
    .xcel_respstream_val (xcel_respstream_val),
    .xcel_respstream_rdy (xcel_respstream_rdy),
    .xcel_respstream_msg (xcel_respstream_msg),
    .memreq_val          (memreq_val),
    .memreq_rdy          (memreq_rdy),
    .memreq_msg          (memreq_msg),
    .memresp_val         (memresp_val),
    .memresp_rdy         (memresp_rdy),
    .memresp_msg         (memresp_msg)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  // memory contents and pending responses
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  typedef struct { logic [7:0] opaque; logic [31:0] data; int ready; } pend_t;
  typedef struct { logic [31:0] addr; logic [7:0] idx; } ereq_t;
  pend_t      pend_q[$];
  ereq_t      exp_req_q[$];
  xcel_resp_t exp_q[$];

  int cyc = 0, lat = 1, outstanding = 0, max_out = 0, n_memreq = 0, calc_cnt = 0;
  bit bp = 1'b0;
  logic [31:0] m_base = '0, m_size = '0, m_sum = '0, last_data = '0;

  // environment drive, just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    memreq_rdy          = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    xcel_respstream_rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    memresp_msg = '0;
    if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
      memresp_val        = 1'b1;
      memresp_msg.type_  = MEM_TYPE_READ;
      memresp_msg.opaque = pend_q[0].opaque;
      memresp_msg.data   = pend_q[0].data;
    end else begin
      memresp_val = 1'b0;
    end
  end

  // model update and comparison on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete(); exp_req_q.delete(); pend_q.delete();
      m_base = '0; m_size = '0; m_sum = '0; outstanding = 0;
    end else begin
      if (xcel_respstream_val && xcel_respstream_rdy) begin
        if (exp_q.size() == 0) fail_now("xcel_resp_unexpected");
        else begin
          xcel_resp_t e;
          e = exp_q.pop_front();
          chk("xcel_resp_opaque", 32'(xcel_respstream_msg.opaque), 32'(e.opaque));
          chk("xcel_resp_type", 32'(xcel_respstream_msg.type_), 32'(e.type_));
          chk("xcel_resp_data", xcel_respstream_msg.data, e.data);
          last_data = xcel_respstream_msg.data;
        end
      end
      if (xcel_reqstream_val && xcel_reqstream_rdy) begin
        xcel_resp_t e;
        e.opaque = xcel_reqstream_msg.opaque;
        e.type_  = xcel_reqstream_msg.type_;
        e.data   = '0;
        if (xcel_reqstream_msg.type_ == XCEL_TYPE_WRITE) begin
          case (xcel_reqstream_msg.addr)
            5'd0: begin
              m_sum = '0;
              for (int i = 0; i < int'(m_size); i++) begin
                ereq_t r;
                r.addr = m_base + 32'(4 * i);
                r.idx  = 8'(i);
                exp_req_q.push_back(r);
                m_sum += mem_rd(r.addr);
              end
            end
            5'd1: m_base = xcel_reqstream_msg.data;
            5'd2: m_size = xcel_reqstream_msg.data;
            default: ;
          endcase
        end else begin
          case (xcel_reqstream_msg.addr)
            5'd0: e.data = m_sum;
            5'd1: e.data = m_base;
            5'd2: e.data = m_size;
            default: e.data = '0;
          endcase
        end
        exp_q.push_back(e);
      end
      if (memreq_val && memreq_rdy) begin
        n_memreq++;
        if (exp_req_q.size() == 0) fail_now("memreq_unexpected");
        else begin
          ereq_t r;
          pend_t p;
          r = exp_req_q.pop_front();
          chk("memreq_addr", memreq_msg.addr, r.addr);
          chk("memreq_opaque", 32'(memreq_msg.opaque), 32'(r.idx));
          chk("memreq_type", 32'(memreq_msg.type_), 32'(MEM_TYPE_READ));
          p.opaque = memreq_msg.opaque;
          p.data   = mem_rd(memreq_msg.addr);
          p.ready  = cyc + lat;
          pend_q.push_back(p);
          outstanding++;
          chk("inflight_bound", 32'(outstanding <= 4), 32'd1);
        end
      end
      if (memresp_val && memresp_rdy && pend_q.size() > 0) begin
        void'(pend_q.pop_front());
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (!xcel_reqstream_rdy) calc_cnt++;
    end
  end

  task automatic xreq(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                      input logic [7:0] op);
    bit ok = 1'b0;
    @(posedge clk); #1;
    xcel_reqstream_val        = 1'b1;
    xcel_reqstream_msg.opaque = op;
    xcel_reqstream_msg.type_  = wr;
    xcel_reqstream_msg.addr   = addr;
    xcel_reqstream_msg.data   = data;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (xcel_reqstream_rdy) ok = 1'b1;
    end
    if (!ok) begin n_chk++; $display("FAIL xreq_timeout: got no accept required accept"); end
    @(posedge clk); #1;
    xcel_reqstream_val = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 5000 && !ok; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && pend_q.size() == 0 && exp_req_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin n_chk++; $display("FAIL drain_timeout: got pending work required none"); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_resp_val", 32'(xcel_respstream_val), 32'd0);
    chk("reset_memreq_val", 32'(memreq_val), 32'd0);
    chk("reset_memresp_rdy", 32'(memresp_rdy), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_req_rdy", 32'(xcel_reqstream_rdy), 32'd1);

    // reset register values
    xreq(0, 5'd0, 0, 8'h01); xreq(0, 5'd1, 0, 8'h02); xreq(0, 5'd2, 0, 8'h03);
    drain();
    chk("lit_reset_size", last_data, 32'd0);

    // configuration readback
    xreq(1, 5'd1, 32'h2000, 8'h11); xreq(1, 5'd2, 3, 8'h12);
    xreq(0, 5'd1, 0, 8'h13);
    drain();
    chk("lit_rd_base", last_data, 32'h2000);
    xreq(0, 5'd2, 0, 8'h14); xreq(1, 5'd7, 32'hdead, 8'h15); xreq(0, 5'd7, 0, 8'h16);
    drain();
    chk("lit_rd_other", last_data, 32'd0);

    // basic sum
    for (int i = 0; i < 4; i++) mem[32'h2000 + 32'(4 * i)] = 32'(i + 1);
    n_memreq = 0;
    xreq(1, 5'd2, 4, 8'h21); xreq(1, 5'd0, 32'h55, 8'h22); xreq(0, 5'd0, 0, 8'h23);
    drain();
    chk("lit_sum_basic", last_data, 32'd10);
    chk("lit_basic_nreq", 32'(n_memreq), 32'd4);

    // overflow wraps
    mem[32'h3000] = 32'hFFFF_FFFF; mem[32'h3004] = 32'd2;
    xreq(1, 5'd1, 32'h3000, 8'h31); xreq(1, 5'd2, 2, 8'h32);
    xreq(1, 5'd0, 0, 8'h33); xreq(0, 5'd0, 0, 8'h34);
    drain();
    chk("lit_sum_overflow", last_data, 32'd1);

    // zero size: one CALC cycle, no memory traffic
    xreq(1, 5'd2, 0, 8'h41);
    drain();
    n_memreq = 0; calc_cnt = 0;
    xreq(1, 5'd0, 0, 8'h42); xreq(0, 5'd0, 0, 8'h43);
    drain();
    chk("lit_sum_zero", last_data, 32'd0);
    chk("lit_zero_nreq", 32'(n_memreq), 32'd0);
    chk("lit_zero_calc_cycles", 32'(calc_cnt), 32'd1);

    // backpressure with slow memory
    for (int i = 0; i < 16; i++) mem[32'h4000 + 32'(4 * i)] = 32'd1;
    bp = 1'b1; lat = 5; max_out = 0;
    xreq(1, 5'd1, 32'h4000, 8'h51); xreq(1, 5'd2, 16, 8'h52);
    xreq(1, 5'd0, 0, 8'h53); xreq(0, 5'd0, 0, 8'h54);
    drain();
    chk("lit_sum_bp", last_data, 32'd16);
    chk("lit_bp_max_inflight_le4", 32'(max_out <= 4), 32'd1);
    chk("lit_bp_max_inflight_gt1", 32'(max_out > 1), 32'd1);
    bp = 1'b0; lat = 1;

    // reset mid-run
    for (int i = 0; i < 8; i++) mem[32'h5000 + 32'(4 * i)] = 32'(i + 1);
    xreq(1, 5'd1, 32'h5000, 8'h61); xreq(1, 5'd2, 8, 8'h62); xreq(1, 5'd0, 0, 8'h63);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    xreq(0, 5'd0, 0, 8'h64);
    drain();
    chk("lit_rst_sum", last_data, 32'd0);
    xreq(0, 5'd2, 0, 8'h65);
    drain();
    chk("lit_rst_size", last_data, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xcel_sum_accel.md
# xcel_sum_accel

Accelerator that answers the processor's xcel request stream. It holds three accelerator registers: `xr1` is the base address, `xr2` is the element count, and a write to `xr0` starts a run. During a run it streams word reads from data memory and sums them. A later read of `xr0` returns the 32-bit sum. It sits between the processor's xcel port and one data-memory port, which it drives as a memory initiator.

## Interface
Parameters:
- `p_max_inflight`, default 4, meaning maximum memory reads issued but not yet answered (power of two, ≥1).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `xcel_reqstream_val` / `_rdy`  in / out  1 / 1  request handshake.
- `xcel_reqstream_msg`  in  `xcel_req_t`  fields: `opaque`[7:0], `type_`[0:0] (0 = read, 1 = write), `addr`[4:0], `data`[31:0].
- `xcel_respstream_val` / `_rdy`  out / in  1 / 1  response handshake.
- `xcel_respstream_msg`  out  `xcel_resp_t`  fields: `opaque`, `type_`, `data`[31:0].
- `memreq_val` / `_rdy`  out / in  1 / 1  memory request handshake.
- `memreq_msg`  out  `mem_req_4B_t`  memory request message.
- `memresp_val` / `_rdy`  in / out  1 / 1  memory response handshake.
- `memresp_msg`  in  `mem_resp_4B_t`  memory response message.

## Operation
- States: `IDLE` and `CALC`.
- Reset values:
  - state is `IDLE`.
  - `base`, `size`, `sum`, `issued`, `received` are 0.
  - `xcel_respstream_val`, `memreq_val` and `memresp_rdy` are 0.
- Request acceptance: `xcel_reqstream_rdy` = `IDLE` && (response slot empty || `xcel_respstream_rdy`).
- Accepted request fills a one-entry response register with the same `opaque` and `type_`.
  - Write to `xr1`: loads `base`. Response data is 0.
  - Write to `xr2`: loads `size`. Response data is 0.
  - Write to `xr0`: clears `sum`, `issued` and `received`, and moves to `CALC`. Response data is 0. The data value is ignored.
  - Write to any other address: ignored. Response data is 0.
  - Read of `xr0`: returns `sum`.
  - Read of `xr1` / `xr2`: returns `base` / `size`.
  - Read of any other address: returns 0.
- `CALC`, request side:
  - `memreq_val` = (`issued` < `size`) && (`issued` − `received` < `p_max_inflight`).
  - Request fields: `type_` = read, `opaque` = `issued`[7:0], `addr` = `base` + 4·`issued` (mod 2^32), `len` = 0 (4 bytes), `data` = 0.
  - `issued` increments on each `memreq` fire.
- `CALC`, response side:
  - `memresp_rdy` = 1.
  - Each `memresp` fire: `sum` ← `sum` + data (mod 2^32), `received`++.
  - Responses arrive in order. `opaque` is not checked.
- Exit: `CALC` → `IDLE` on the cycle `received` == `size`, counting the response accepted that cycle.
  - `size` == 0: exits after exactly one `CALC` cycle with `sum` = 0 and no memory traffic.
- `memresp_val` while `IDLE`: not accepted (`memresp_rdy` = 0). This cannot occur in legal use.
- While `CALC`, `xcel_reqstream_rdy` = 0. A read of `xr0` issued right after go therefore blocks until the sum is final.
- Reset mid-run: all state returns to reset values. In-flight memory responses are the environment's responsibility.

## Timing
- Xcel response: `xcel_respstream_val` rises the cycle after request acceptance.
  - It is held, with the message stable, until `xcel_respstream_rdy`.
- Back-to-back requests: one accepted per cycle when the response side is always ready.
- Go write:
  - Its response becomes valid the cycle after acceptance, while in `CALC`.
  - The first `memreq_val` is in that same cycle.
- Throughput: one memory request per cycle while credits remain.
- Run time:
  - With 1-cycle memory and `size` = N ≥ 1: `IDLE` is re-entered N+1 cycles after the go is accepted.
  - The earliest `xr0` read response follows 1 cycle after that read is accepted.
- `memreq_val` does not depend combinationally on `memreq_rdy`.
- `xcel_reqstream_rdy` depends on `xcel_respstream_rdy` (bypass-style).

## Structure
- Shared package `xcel_msgs`:
  - `xcel_req_t`, `xcel_resp_t`.
  - Constants `XCEL_TYPE_READ`/`_WRITE`.
  - Register indices `XR_GO`/`XR_BASE`/`XR_SIZE` = 0/1/2.
- `mem_req_4B_t` / `mem_resp_4B_t` come from the existing memory-message package.
- One sub-module, `xcel_sum_accel_ctrl`: state register, counters, credit comparison, val/rdy logic. Registers and the adder stay in the top-level datapath.

## Test plan
- Configuration readback: write `xr1` = 0x2000, write `xr2` = 3, read `xr1`, read `xr2` → responses 0, 0, 0x2000, 3, with `opaque` echoed.
- Basic sum: memory at 0x2000 holds {1, 2, 3, 4}, `size` = 4, go, read `xr0` → memory requests to 0x2000 through 0x200C in order, then `xr0` = 10.
- Overflow: memory holds {0xFFFFFFFF, 2}, `size` = 2 → `xr0` = 1.
- Zero size: `size` = 0, go, read `xr0` → 0, no `memreq_val`, `CALC` lasts one cycle.
- Backpressure: random `memreq_rdy`, random `xcel_respstream_rdy`, memory latency 5 cycles, `size` = 16 with all data = 1.
  - Outstanding reads never exceed `p_max_inflight`; `xr0` = 16.
- Reset mid-run: assert reset during a `size` = 8 run, then read `xr0` → 0, and `xr2` read → 0.
